// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side checker for the lab random-number generator's serial pattern:
// a 16-bit XNOR LFSR with taps 15, 13, 12, 10 whose new bit,
// NOT(s[15]^s[13]^s[12]^s[10]), is shifted into bit 0.
//
// The checker first loads its own copy of the generator state straight from
// the stream (FILL), then confirms that the next LOCK_GOOD bits are exactly
// what that state predicts (VERIFY). Once locked, it runs its reference
// register freely and compares every received bit against the prediction,
// pulsing bit_error_o and counting mismatches. LOSS_THRESH consecutive
// mismatches drop lock and restart the fill.
//
// Parameters
//   LOCK_GOOD    consecutive good predictions needed to declare lock (1..255)
//   LOSS_THRESH  consecutive mispredictions in LOCKED that drop lock (1..255)
//   CNT_W        width of the saturating error counter
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset, clears everything
//   bit_valid_i    in   strobe; bit_in_i is only sampled when this is 1
//   bit_in_i       in   received pattern bit
//   clear_count_i  in   synchronous clear of error_count_o, wins over +1
//   locked_o       out  registered, 1 while the checker is locked
//   bit_error_o    out  registered one-cycle pulse per mispredicted bit
//   error_count_o  out  registered saturating count of bit_error_o pulses
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int unsigned LOCK_GOOD   = 16,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid_i,
  input  logic             bit_in_i,
  input  logic             clear_count_i,
  output logic             locked_o,
  output logic             bit_error_o,
  output logic [CNT_W-1:0] error_count_o
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [7:0]       LOCK_GOOD_C = 8'(LOCK_GOOD);
  localparam logic [7:0]       LOSS_C      = 8'(LOSS_THRESH);
  localparam logic [4:0]       FILL_LAST   = 5'd15;
  localparam logic [15:0]      LOCKUP      = 16'hFFFF;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [15:0]      sr_q, sr_d;
  logic [4:0]       fill_q, fill_d;
  logic [7:0]       good_q, good_d;
  logic [7:0]       bad_q, bad_d;
  logic             locked_q, locked_d;
  logic             bit_error_q, bit_error_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             pred;
  logic             mismatch;
  logic [15:0]      sr_rx_shift;
  logic [7:0]       good_inc;
  logic [7:0]       bad_inc;

  // Prediction of the next stream bit from the current reference state.
  assign pred        = ~(sr_q[15] ^ sr_q[13] ^ sr_q[12] ^ sr_q[10]);
  assign mismatch    = (bit_in_i != pred);
  assign sr_rx_shift = {sr_q[14:0], bit_in_i};
  assign good_inc    = good_q + 8'd1;
  assign bad_inc     = bad_q + 8'd1;

  // All state lives here; reset aborts any fill or lock in progress at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      sr_q        <= '0;
      fill_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      bit_error_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      bit_error_q <= bit_error_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic. Only strobed cycles move the FSM or the reference
  // register; idle cycles hold everything except the bit_error pulse, which
  // is low on any cycle that did not just sample a bad bit.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    good_d      = good_q;
    bad_d       = bad_q;
    bit_error_d = 1'b0;
    count_d     = count_q;

    if (bit_valid_i) begin
      unique case (state_q)
        FILL: begin
          sr_d = sr_rx_shift;
          if (fill_q == FILL_LAST) begin
            fill_d = '0;
            // All-ones is the XNOR lock-up state; the generator can never
            // be there, so this fill was garbage and we start again.
            if (sr_rx_shift != LOCKUP) begin
              state_d = VERIFY;
              good_d  = '0;
            end
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end

        VERIFY: begin
          // Still tracking the received bits, not the prediction, since we
          // have not yet earned the right to trust the loaded state.
          sr_d = sr_rx_shift;
          if (!mismatch) begin
            good_d = good_inc;
            if (good_inc == LOCK_GOOD_C) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            state_d = FILL;
            fill_d  = '0;
          end
        end

        LOCKED: begin
          // Free-running reference: a single corrupted line bit must not
          // poison the state and produce a string of follow-on errors.
          sr_d = {sr_q[14:0], pred};
          if (mismatch) begin
            bit_error_d = 1'b1;
            bad_d       = bad_inc;
            if (count_q != CNT_MAX) begin
              count_d = count_q + CNT_ONE;
            end
            if (bad_inc == LOSS_C) begin
              state_d = FILL;
              fill_d  = '0;
            end
          end else begin
            bad_d = '0;
          end
        end

        default: begin
          state_d = FILL;
          fill_d  = '0;
        end
      endcase
    end

    // A clear wins over a simultaneous increment; that error is dropped
    // from the count although its pulse still goes out.
    if (clear_count_i) begin
      count_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  assign locked_o      = locked_q;
  assign bit_error_o   = bit_error_q;
  assign error_count_o = count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//
// Drives lfsr_checker with the lab generator's pattern (optionally with
// injected bit errors, idle gaps and counter clears) and compares every
// cycle's outputs against a reference model. The reference keeps the last
// sixteen reference bits in a queue and tracks the checker's progress as
// simple counts of filled, confirmed and consecutive bad bits.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam int LOCK_GOOD   = 16;
  localparam int LOSS_THRESH = 8;
  localparam int CNT_W       = 4;
  localparam int CNT_SAT     = (1 << CNT_W) - 1;

  localparam int PH_SYNC    = 0;
  localparam int PH_CONFIRM = 1;
  localparam int PH_TRACK   = 2;

  logic             clk;
  logic             reset;
  logic             bitValid;
  logic             bitIn;
  logic             clearCount;
  logic             locked;
  logic             bitError;
  logic [CNT_W-1:0] errorCount;

  lfsr_checker #(
    .LOCK_GOOD   (LOCK_GOOD),
    .LOSS_THRESH (LOSS_THRESH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bit_valid_i   (bitValid),
    .bit_in_i      (bitIn),
    .clear_count_i (clearCount),
    .locked_o      (locked),
    .bit_error_o   (bitError),
    .error_count_o (errorCount)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCnt = 0;
  int errCnt   = 0;

  // Generator state and model state.
  logic [15:0] gen;
  int hist[$];
  int phase;
  int filled;
  int confirmed;
  int badRun;
  int expCount;
  int expErr;
  int expLocked;
  int validSent;

  // Single comparison point; every check in the bench comes through here.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCnt++;
    if (observed != expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Next bit out of the lab generator.
  task automatic genNext(output logic b);
    b   = ~(gen[15] ^ gen[13] ^ gen[12] ^ gen[10]);
    gen = {gen[14:0], b};
  endtask

  function automatic int modelPred();
    return 1 - (hist[0] ^ hist[2] ^ hist[3] ^ hist[5]);
  endfunction

  function automatic void modelPush(input int b);
    hist.push_back(b);
    void'(hist.pop_front());
  endfunction

  function automatic void modelReset();
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back(0);
    phase     = PH_SYNC;
    filled    = 0;
    confirmed = 0;
    badRun    = 0;
    expCount  = 0;
    expErr    = 0;
    expLocked = 0;
  endfunction

  // One sampled cycle as the checker is meant to see it.
  function automatic void modelStep(input int v, input int b, input int clr);
    int p;
    int ones;
    expErr = 0;
    if (v != 0) begin
      if (phase == PH_SYNC) begin
        modelPush(b);
        filled++;
        if (filled == 16) begin
          filled = 0;
          ones = 0;
          foreach (hist[i]) ones += hist[i];
          if (ones != 16) begin
            phase     = PH_CONFIRM;
            confirmed = 0;
          end
        end
      end else if (phase == PH_CONFIRM) begin
        p = modelPred();
        modelPush(b);
        if (b == p) begin
          confirmed++;
          if (confirmed == LOCK_GOOD) begin
            phase  = PH_TRACK;
            badRun = 0;
          end
        end else begin
          phase  = PH_SYNC;
          filled = 0;
        end
      end else begin
        p = modelPred();
        modelPush(p);
        if (b != p) begin
          expErr = 1;
          if (expCount < CNT_SAT) expCount++;
          badRun++;
          if (badRun == LOSS_THRESH) begin
            phase  = PH_SYNC;
            filled = 0;
          end
        end else begin
          badRun = 0;
        end
      end
    end
    if (clr != 0) expCount = 0;
    expLocked = (phase == PH_TRACK) ? 1 : 0;
  endfunction

  // Drive one cycle, advance the model on the edge, check just after it.
  task automatic applyStimulus(input logic v, input logic b, input logic clr);
    bitValid   = v;
    bitIn      = b;
    clearCount = clr;
    @(posedge clk);
    modelStep(int'(v), int'(b), int'(clr));
    if (v) validSent++;
    #1;
    checkOutput("locked", int'(locked), expLocked);
    checkOutput("bitError", int'(bitError), expErr);
    checkOutput("errorCount", int'(errorCount), expCount);
  endtask

  task automatic streamBit(input logic invert, input logic clr);
    logic b;
    genNext(b);
    applyStimulus(1'b1, b ^ invert, clr);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'($urandom_range(1)), 1'b0);
  endtask

  // Asynchronous reset taken away from any clock edge; outputs must clear
  // without waiting for a clock.
  task automatic resetDut();
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rstLocked", int'(locked), 0);
    checkOutput("rstBitError", int'(bitError), 0);
    checkOutput("rstCount", int'(errorCount), 0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    validSent = 0;
  endtask

  // Clean stream with optional idle gaps until locked; returns the number
  // of valid bits sent since the call, or -1 if the budget ran out.
  task automatic streamUntilLock(input int gapPct, input int maxCycles, output int lockAt);
    int start;
    start  = validSent;
    lockAt = -1;
    for (int c = 0; c < maxCycles && lockAt < 0; c++) begin
      if (int'($urandom_range(99)) < gapPct) idleCycle();
      else streamBit(1'b0, 1'b0);
      if (locked) lockAt = validSent - start;
    end
  endtask

  initial begin
    int lockAt;
    int pulses;
    int sawLock;
    int rate;

    reset      = 1'b1;
    bitValid   = 1'b0;
    bitIn      = 1'b0;
    clearCount = 1'b0;
    gen        = 16'h0000;
    validSent  = 0;
    modelReset();

    // Clean stream at full rate from a zeroed generator.
    resetDut();
    streamUntilLock(0, 100, lockAt);
    checkOutput("lockLatency", lockAt, 32);
    while (validSent < 200) streamBit(1'b0, 1'b0);
    checkOutput("cleanLocked", int'(locked), 1);
    checkOutput("cleanCount", int'(errorCount), 0);

    // Single inverted bit (bit 100 from reset) while locked.
    resetDut();
    gen    = 16'h0000;
    pulses = 0;
    for (int i = 1; i <= 150; i++) begin
      streamBit((i == 100) ? 1'b1 : 1'b0, 1'b0);
      pulses += int'(bitError);
    end
    checkOutput("singlePulses", pulses, 1);
    checkOutput("singleCount", int'(errorCount), 1);
    checkOutput("singleLocked", int'(locked), 1);

    // Stuck-at-one line: every fill lands in the lock-up state.
    resetDut();
    sawLock = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (locked) sawLock = 1;
    end
    checkOutput("stuckNoLock", sawLock, 0);
    checkOutput("stuckCount", int'(errorCount), 0);

    // Burst of LOSS_THRESH inverted bits drops lock, then relock.
    resetDut();
    streamUntilLock(0, 100, lockAt);
    for (int i = 0; i < 10; i++) streamBit(1'b0, 1'b0);
    for (int i = 0; i < LOSS_THRESH; i++) streamBit(1'b1, 1'b0);
    checkOutput("burstUnlocked", int'(locked), 0);
    checkOutput("burstCount", int'(errorCount), 8);
    streamUntilLock(0, 100, lockAt);
    checkOutput("relockLatency", lockAt, 32);
    checkOutput("relockCount", int'(errorCount), 8);

    // Saturation of the narrow counter, then clear on an error cycle.
    resetDut();
    streamUntilLock(0, 100, lockAt);
    for (int i = 0; i < 20; i++) begin
      streamBit(1'b1, 1'b0);
      for (int k = 0; k < 3; k++) streamBit(1'b0, 1'b0);
    end
    checkOutput("satCount", int'(errorCount), CNT_SAT);
    checkOutput("satLocked", int'(locked), 1);
    streamBit(1'b1, 1'b1);
    checkOutput("clearOnErrCount", int'(errorCount), 0);
    checkOutput("clearOnErrPulse", int'(bitError), 1);

    // 50% duty strobes, reset in the middle of LOCKED, relock count.
    resetDut();
    streamUntilLock(50, 300, lockAt);
    checkOutput("gapLockLatency", lockAt, 32);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(1) == 0) idleCycle();
      else streamBit(1'b0, 1'b0);
    end
    resetDut();
    streamUntilLock(50, 300, lockAt);
    checkOutput("postResetRelock", lockAt, 32);

    // Random mix of error rates, gaps and clears against the model.
    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 4)
        0: rate = 0;
        1: rate = 5;
        2: rate = 60;
        default: rate = 15;
      endcase
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(99) < 30) idleCycle();
        else streamBit(1'(int'($urandom_range(99)) < rate),
                       1'($urandom_range(39) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

  // Safety net in case a wait ever hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got 0, expected 1 (run did not complete)");
    errCnt++;
    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $fatal(1, "[TB] timeout");
  end

endmodule
